// File: rtl/packet_receiver.sv
// Receive end of the lasernet packet link: collects a 9-word packet, validates
// the folded checksum and writes in-window payloads into a reassembly buffer.
module packet_receiver #(
  parameter int unsigned NSLOTS  = 5,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             ISN,
  input  logic [31:0]             word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  input  logic                    msg_clear,
  output logic                    pkt_valid,
  output logic [31:0]             pkt_seq,
  output logic [31:0]             pkt_ack,
  output logic [8:0]              pkt_flags,
  output logic [15:0]             pkt_window,
  output logic [127:0]            pkt_data,
  output logic                    checksum_ok,
  output logic                    pkt_abort,
  output logic [128*NSLOTS-1:0]   message,
  output logic [NSLOTS-1:0]       slot_written
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t              state_q, state_d;
  logic [31:0]         words_q [9];
  logic [3:0]          cnt_q;
  logic [31:0]         sum_q;
  logic [IDLE_W-1:0]   idle_q;
  logic                accept;
  logic                timeout_hit;
  logic [31:0]         halves;
  logic [15:0]         fold;
  logic [15:0]         calc;
  logic                csum_ok;
  logic [31:0]         slot_idx;
  logic                wr_en;

  logic                pkt_valid_q, checksum_ok_q, pkt_abort_q;
  logic [31:0]         pkt_seq_q, pkt_ack_q;
  logic [8:0]          pkt_flags_q;
  logic [15:0]         pkt_window_q;
  logic [127:0]        pkt_data_q;
  logic [128*NSLOTS-1:0] message_q;
  logic [NSLOTS-1:0]   slot_written_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = RECV;
      RECV: begin
        if (accept && cnt_q == 4'd8) begin
          state_d = CHECK;
        end else if (!accept && idle_q == IDLE_W'(TIMEOUT - 1)) begin
          state_d     = IDLE;
          timeout_hit = 1'b1;
        end
      end
      CHECK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word_ready = (state_q != CHECK);
    accept     = word_valid && word_ready;
    halves     = {16'b0, word_in[31:16]} + {16'b0, word_in[15:0]};
    // End-around carry: a wrapped fold means one more carry is still owed.
    fold       = sum_q[31:16] + sum_q[15:0];
    calc       = (fold < sum_q[15:0]) ? ~(fold + 16'd1) : ~fold;
    csum_ok    = (calc == words_q[4][31:16]) && (words_q[4][15:0] == 16'h0000) &&
                 (words_q[3][31:25] == 7'h00);
    slot_idx   = words_q[1] - ISN - 32'd1;
    wr_en      = (state_q == CHECK) && csum_ok && (slot_idx < NSLOTS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 9; i++) words_q[i] <= '0;
      cnt_q          <= '0;
      sum_q          <= '0;
      idle_q         <= '0;
      pkt_valid_q    <= 1'b0;
      pkt_abort_q    <= 1'b0;
      checksum_ok_q  <= 1'b0;
      pkt_seq_q      <= '0;
      pkt_ack_q      <= '0;
      pkt_flags_q    <= '0;
      pkt_window_q   <= '0;
      pkt_data_q     <= '0;
      message_q      <= '0;
      slot_written_q <= '0;
    end else begin
      pkt_valid_q <= 1'b0;
      pkt_abort_q <= timeout_hit;
      if (accept) words_q[cnt_q] <= word_in;
      case (state_q)
        IDLE: begin
          idle_q <= '0;
          if (accept) begin
            cnt_q <= 4'd1;
            sum_q <= halves;
          end
        end
        RECV: begin
          if (accept) begin
            cnt_q  <= cnt_q + 4'd1;
            idle_q <= '0;
            if (cnt_q != 4'd4) sum_q <= sum_q + halves;
          end else if (timeout_hit) begin
            cnt_q  <= '0;
            idle_q <= '0;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        CHECK: begin
          cnt_q         <= '0;
          idle_q        <= '0;
          pkt_valid_q   <= 1'b1;
          checksum_ok_q <= csum_ok;
          pkt_seq_q     <= words_q[1];
          pkt_ack_q     <= words_q[2];
          pkt_flags_q   <= words_q[3][24:16];
          pkt_window_q  <= words_q[3][15:0];
          pkt_data_q    <= {words_q[5], words_q[6], words_q[7], words_q[8]};
        end
        default: cnt_q <= '0;
      endcase
      if (msg_clear) begin
        message_q      <= '0;
        slot_written_q <= '0;
      end else if (wr_en) begin
        for (int unsigned i = 0; i < NSLOTS; i++) begin
          if (slot_idx == i) begin
            message_q[128*i +: 128] <= {words_q[5], words_q[6], words_q[7], words_q[8]};
            slot_written_q[i]       <= 1'b1;
          end
        end
      end
    end
  end

  assign pkt_valid    = pkt_valid_q;
  assign pkt_abort    = pkt_abort_q;
  assign checksum_ok  = checksum_ok_q;
  assign pkt_seq      = pkt_seq_q;
  assign pkt_ack      = pkt_ack_q;
  assign pkt_flags    = pkt_flags_q;
  assign pkt_window   = pkt_window_q;
  assign pkt_data     = pkt_data_q;
  assign message      = message_q;
  assign slot_written = slot_written_q;

endmodule
